// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: display data/control inputs and driven segment/anode outputs of the scanner
interface seven_seg_scanner_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic [DIGITS-1:0]   dp_in;
  logic                lz_en;
  logic                blank;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_tick;
  modport master (
    output value, load, dp_in, lz_en, blank,
    input  seg, dp, an, frame_tick
  );
  modport slave (
    input  value, load, dp_in, lz_en, blank,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed hex display driver with guard blanking and leading-zero suppression
module seven_seg_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input logic               clk,
  input logic               reset_n,
  seven_seg_scanner_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dpm_q, dpm_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                tick_q, tick_d;
  logic                slot_end, last, off, supp;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   upper_nz;
  logic                acc;
  // upper_nz[k]: nibble k or any more significant nibble is non-zero
  always_comb begin
    upper_nz = '0;
    acc = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc = acc | (|val_q[4*k +: 4]);
      upper_nz[k] = acc;
    end
  end
  always_comb begin
    slot_end = pcnt_q == PW'(REFRESH_DIV - 1);
    last     = idx_q == IW'(DIGITS - 1);
    pcnt_d   = slot_end ? '0 : pcnt_q + 1'b1;
    idx_d    = slot_end ? (last ? '0 : idx_q + 1'b1) : idx_q;
    val_d    = bus.load ? bus.value : val_q;
    dpm_d    = bus.load ? bus.dp_in : dpm_q;
    nib      = val_q[{idx_q, 2'b00} +: 4];
    supp     = bus.lz_en && (idx_q != '0) && !upper_nz[idx_q];
    off      = bus.blank || (pcnt_q < PW'(BLANK_CYC));
    an_d     = off ? '1 : ~(DIGITS'(1) << idx_q);
    seg_d    = (off || supp) ? 7'h7f : SEG_LUT[nib];
    dp_d     = off ? 1'b1 : ~dpm_q[idx_q];
    tick_d   = slot_end && last;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
      idx_q  <= '0;
      val_q  <= '0;
      dpm_q  <= '0;
      seg_q  <= 7'h7f;
      dp_q   <= 1'b1;
      an_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      val_q  <= val_d;
      dpm_q  <= dpm_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed vector bench for the 4-digit scanner plus a 1-digit instance
module tb_seven_seg_scanner;
  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dpv;
    logic            lz;
    logic            bl;
    logic [3:0][6:0] segs;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n = 0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs [7];
  vec_t rz;
  seven_seg_scanner_if #(.DIGITS(4)) bus ();
  seven_seg_scanner_if #(.DIGITS(1)) bus1 ();
  seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  seven_seg_scanner #(.DIGITS(1), .REFRESH_DIV(4), .BLANK_CYC(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask
  task automatic chk(input vec_t v, input string nm);
    int s, p, i;
    logic [3:0] ean;
    logic [6:0] es;
    logic edp, et, off;
    s   = n - 1;
    p   = s % 8;
    i   = (s / 8) % 4;
    off = v.bl || (p < 2);
    ean = off ? 4'hF : ~(4'b0001 << i);
    es  = off ? 7'h7f : v.segs[i];
    edp = off ? 1'b1 : ~v.dpv[i];
    et  = (n % 32) == 0;
    total++;
    if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {ean, es, edp, et}) begin
      bad++;
      $display("FAIL %s n=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
               nm, n, bus.an, bus.seg, bus.dp, bus.frame_tick, ean, es, edp, et);
    end
  endtask
  task automatic chk1();
    logic off;
    logic [9:0] e;
    off = ((n - 1) % 4) < 1;
    e = {off ? 1'b1 : 1'b0, off ? 7'h7f : 7'b0000001, 1'b1, (n % 4) == 0};
    total++;
    if ({bus1.an, bus1.seg, bus1.dp, bus1.frame_tick} !== e) begin
      bad++;
      $display("FAIL one_digit n=%0d got %b want %b", n,
               {bus1.an, bus1.seg, bus1.dp, bus1.frame_tick}, e);
    end
  endtask
  task automatic chk_off(input string nm);
    total++;
    if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {4'hF, 7'h7f, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL %s got an=%b seg=%b dp=%b tick=%b want an=1111 seg=1111111 dp=1 tick=0",
               nm, bus.an, bus.seg, bus.dp, bus.frame_tick);
    end
  endtask
  task automatic load(input vec_t v);
    bus.lz_en = v.lz;
    bus.blank = v.bl;
    bus.value = v.value;
    bus.dp_in = v.dpv;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
    bus.value = 16'hFFFF;
    bus.dp_in = 4'hF;
  endtask
  task automatic align(input int ph);
    while ((n % 32) != ph) tick();
  endtask
  initial begin
    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, 1'b0, {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}};
    vecs[1] = '{16'h0005, 4'b0010, 1'b1, 1'b0, {7'h7f, 7'h7f, 7'h7f, 7'b0100100}};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 1'b0, {7'h7f, 7'h7f, 7'h7f, 7'b0000001}};
    vecs[3] = '{16'h0B06, 4'b0000, 1'b1, 1'b0, {7'h7f, 7'b1100000, 7'b0000001, 7'b0100000}};
    vecs[4] = '{16'h4D79, 4'b0100, 1'b0, 1'b0, {7'b1001100, 7'b1000010, 7'b0001111, 7'b0001100}};
    vecs[5] = '{16'h3CE8, 4'b1011, 1'b0, 1'b0, {7'b0000110, 7'b0110001, 7'b0110000, 7'b0000000}};
    vecs[6] = '{16'h12AF, 4'b1111, 1'b0, 1'b1, {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}};
    rz      = '{16'h0000, 4'b0000, 1'b0, 1'b0, {4{7'b0000001}}};
    bus.value = 16'h0; bus.load = 1'b0; bus.dp_in = 4'h0; bus.lz_en = 1'b0; bus.blank = 1'b0;
    bus1.value = 4'h0; bus1.load = 1'b0; bus1.dp_in = 1'b0; bus1.lz_en = 1'b0; bus1.blank = 1'b0;
    repeat (3) @(negedge clk);
    chk_off("reset_state");
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < 32; c++) begin
      tick();
      chk(rz, "first_frame");
      chk1();
    end
    for (int k = 0; k < 7; k++) begin
      load(vecs[k]);
      align(0);
      for (int c = 0; c < 32; c++) begin
        tick();
        chk(vecs[k], $sformatf("vec%0d", k));
      end
    end
    bus.blank = 1'b0;
    bus.lz_en = 1'b0;
    load(vecs[0]);
    align(0);
    for (int c = 0; c < 15; c++) begin
      tick();
      chk(vecs[0], "midload_before");
    end
    bus.value = vecs[4].value;
    bus.dp_in = vecs[4].dpv;
    bus.load  = 1'b1;
    tick();
    chk(vecs[0], "midload_edge");
    bus.load  = 1'b0;
    bus.value = 16'hFFFF;
    bus.dp_in = 4'hF;
    for (int c = 0; c < 16; c++) begin
      tick();
      chk(vecs[4], "midload_after");
    end
    while ((n % 32) != 21) begin
      tick();
      chk(vecs[4], "pre_reset");
    end
    #2 reset_n = 1'b0;
    #1 chk_off("async_reset");
    repeat (3) begin
      @(negedge clk);
      chk_off("reset_hold");
    end
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < 32; c++) begin
      tick();
      chk(rz, "after_reset");
      chk1();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The module SHALL have parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 The module SHALL have parameter REFRESH_DIV, default 100000: clocks per digit slot, legal range 2..2^20.
REQ-003 The module SHALL have parameter BLANK_CYC, default 16: anode-off guard clocks at the start of each slot, legal range 0..REFRESH_DIV-1.
REQ-004 Port clk, input, 1: the single system clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port value, input, 4*DIGITS: hex nibbles; nibble k is value[4k+3:4k]; digit 0 is least significant.
REQ-007 Port load, input, 1: capture strobe for value and dp_in.
REQ-008 Port dp_in, input, DIGITS: decimal point request per digit, 1 = lit.
REQ-009 Port lz_en, input, 1: leading-zero suppression enable, sampled live.
REQ-010 Port blank, input, 1: global display off, sampled live.
REQ-011 Port seg, output, 7: {a,b,c,d,e,f,g}, active-low, registered.
REQ-012 Port dp, output, 1: decimal point, active-low, registered.
REQ-013 Port an, output, DIGITS: digit anodes, active-low, one-hot-low or all-high, registered.
REQ-014 Port frame_tick, output, 1: one-clock pulse at the end of each full scan, registered.

Function
REQ-015 On a clock edge with load=1, the shadow registers SHALL capture value and dp_in; the display SHALL use only the shadow registers, never value or dp_in directly.
REQ-016 Prescaler pcnt SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-017 Digit index idx SHALL increment when pcnt=REFRESH_DIV-1 and wrap from DIGITS-1 to 0.
REQ-018 frame_tick SHALL be 1 for exactly the one cycle following the edge on which idx wraps from DIGITS-1 to 0; otherwise 0.
REQ-019 Outputs SHALL register the decode of the current (idx, pcnt), so they lag the counters by one clock.
REQ-020 Guard interval: while pcnt < BLANK_CYC, an SHALL be all ones, seg SHALL be 7'b1111111 and dp SHALL be 1.
REQ-021 Active interval: while pcnt >= BLANK_CYC, an[idx] SHALL be 0 and all other anode bits 1.
REQ-022 Decode, active-low {a..g}: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, c=0110001, d=1000010, E=0110000, F=0111000.
REQ-023 During the active interval, dp SHALL be the inverse of shadow dp bit idx.
REQ-024 With lz_en=1, digit k>0 SHALL be suppressed when its nibble and all more significant nibbles are 0; a suppressed digit drives seg=1111111, dp still follows REQ-023, and its anode still follows REQ-021.
REQ-025 Digit 0 SHALL never be suppressed.
REQ-026 With blank=1, an SHALL be all ones, seg=1111111 and dp=1 regardless of interval; the counters and frame_tick SHALL keep running.
REQ-027 A load coinciding with a slot change or frame wrap SHALL take effect for the new slot with no lost or duplicated slot.
REQ-028 With DIGITS=1, idx SHALL stay 0 and frame_tick SHALL pulse once every REFRESH_DIV clocks.

Reset
REQ-029 While reset_n=0, asynchronously: pcnt=0, idx=0, shadow value=0, shadow dp=0, an=all ones, seg=1111111, dp=1, frame_tick=0.
REQ-030 After reset_n deasserts, the first slot SHALL be digit 0 starting at pcnt=0.
REQ-031 Reset asserted mid-slot SHALL abort the scan immediately with no further frame_tick.

Verification (DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2)
REQ-032 Load value=16'h12AF, dp_in=4'b0000, lz_en=0 -> per slot 2 clocks all-off, then 6 clocks with an=1110/seg=0111000, an=1101/seg=0001000, an=1011/seg=0010010, an=0111/seg=1001111 in slot order.
REQ-033 Free run from reset -> frame_tick pulses every 32 clocks, first pulse one cycle after the edge ending slot 3.
REQ-034 Load value=16'h0005, lz_en=1 -> digits 3..1 seg=1111111 with anodes still scanning, digit 0 seg=0100100; value=16'h0000 -> digit 0 shows 0000001.
REQ-035 Load dp_in=4'b0100 -> dp=0 only in the active interval of slot 2; assert blank=1 -> an=1111 and dp=1 while frame_tick continues every 32 clocks.
REQ-036 Assert reset_n=0 at pcnt=5 of slot 2 -> same cycle an=1111, seg=1111111; after release, slot 0 resumes from pcnt=0 and the shadow value is 0.
REQ-037 Pulse load on the edge where idx goes 1->2 -> slot 2 shows the new nibble from its first active cycle; no slot is skipped or repeated.
